// File: rtl/binary_frame_readout_ctrl.sv
// Raster readout of the 1-bit/pixel binarized frame buffer into a valid/ready pixel stream.
// One start pulse runs one full pass and tags end-of-line and end-of-frame pixels.
module binary_frame_readout_ctrl #(
   parameter int unsigned WIDTH  = 1920,
   parameter int unsigned HEIGHT = 1080,
   parameter int unsigned ADDR_W = 21
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_pixel,
   output logic              out_eol,
   output logic              out_eof
);

   localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StHold, StDone} state_e;

   state_e            state_q, state_d;
   logic [COL_W-1:0]  col_q;
   logic [ROW_W-1:0]  row_q;
   logic [ADDR_W-1:0] addr_q;
   logic              col_last, row_last, frame_last;
   logic              handshake, advance;

   assign col_last   = (col_q == COL_W'(WIDTH - 1));
   assign row_last   = (row_q == ROW_W'(HEIGHT - 1));
   assign frame_last = col_last && row_last;
   // abort wins over a simultaneous handshake: that pixel counts as not delivered
   assign handshake  = (state_q == StHold) && out_ready && !abort;
   assign advance    = handshake && !frame_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start) state_d = StWait;
         StWait: state_d = abort ? StIdle : StHold;
         StHold: begin
            if (abort) begin
               state_d = StIdle;
            end else if (out_ready) begin
               state_d = frame_last ? StDone : StWait;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy      = (state_q != StIdle);
      done      = (state_q == StDone);
      out_valid = (state_q == StHold);
      mem_rd_en = ((state_q == StIdle) && start) || advance;
      mem_addr  = advance ? addr_q + ADDR_W'(1) : addr_q;
   end

   // Counters track the pixel currently fetched or held; addr advances linearly.
   always_ff @(posedge clk) begin
      if (rst || (abort && (state_q != StIdle))) begin
         col_q     <= '0;
         row_q     <= '0;
         addr_q    <= '0;
         out_pixel <= 1'b0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
      end else if (state_q == StWait) begin
         out_pixel <= mem_rd_data;
         out_eol   <= col_last;
         out_eof   <= frame_last;
      end else if (handshake) begin
         if (frame_last) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
         end else begin
            addr_q <= addr_q + ADDR_W'(1);
            if (col_last) begin
               col_q <= '0;
               row_q <= row_q + ROW_W'(1);
            end else begin
               col_q <= col_q + COL_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_binary_frame_readout_ctrl.sv
// Directed bench for binary_frame_readout_ctrl: a 4x3 instance for the main scenarios
// and a 1x3 instance for the degenerate-width case.
module tb_binary_frame_readout_ctrl;

   localparam int unsigned W  = 4;
   localparam int unsigned H  = 3;
   localparam int unsigned AW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start, abort, out_ready;
   logic          busy, done, mem_rd_en, mem_rd_data, out_valid, out_pixel, out_eol, out_eof;
   logic [AW-1:0] mem_addr;

   logic       d1_start, d1_abort, d1_ready;
   logic       d1_busy, d1_done, d1_rd_en, d1_rd_data, d1_valid, d1_pixel, d1_eol, d1_eof;
   logic [1:0] d1_addr;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   binary_frame_readout_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
      .out_eol(out_eol), .out_eof(out_eof)
   );

   binary_frame_readout_ctrl #(.WIDTH(1), .HEIGHT(3), .ADDR_W(2)) u_dut1 (
      .clk(clk), .rst(rst), .start(d1_start), .abort(d1_abort), .busy(d1_busy),
      .done(d1_done), .mem_rd_en(d1_rd_en), .mem_addr(d1_addr), .mem_rd_data(d1_rd_data),
      .out_valid(d1_valid), .out_ready(d1_ready), .out_pixel(d1_pixel),
      .out_eol(d1_eol), .out_eof(d1_eof)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Buffer models: registered read, latency 1
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= ~mem_addr[0];
   always @(posedge clk) if (d1_rd_en) d1_rd_data <= (d1_addr != 2'd2);

   // Observation logs for the 4x3 instance; they only grow, tests index from a base.
   logic [2:0] obs_q[$];
   int         addr_q[$];
   int         done_n    = 0;
   int         done_cyc  = 0;
   int         stall_bad = 0;
   logic       prev_stall = 1'b0;
   logic [2:0] prev_obs   = 3'b000;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall <= 1'b0;
      end else begin
         if (mem_rd_en) addr_q.push_back(int'(mem_addr));
         if (out_valid && out_ready && !abort) obs_q.push_back({out_pixel, out_eol, out_eof});
         if (done) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
         end
         if ((prev_stall && (!out_valid || ({out_pixel, out_eol, out_eof} !== prev_obs))) ||
             (out_valid && !out_ready && mem_rd_en))
            stall_bad <= stall_bad + 1;
         prev_stall <= out_valid && !out_ready && !abort;
         prev_obs   <= {out_pixel, out_eol, out_eof};
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one pass; optionally re-pulses start while the pixel count equals start_hs.
   task automatic run_frame(input bit bp, input int start_hs, output int start_c,
                            output bit timed_out);
      int d0 = done_n;
      int h0 = obs_q.size();
      start     = 1'b1;
      start_c   = cyc;
      out_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      step();
      timed_out = 1'b1;
      for (int i = 0; i < 400; i++) begin
         out_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
         start     = ((obs_q.size() - h0) == start_hs) && out_valid;
         step();
         if (done_n != d0) begin
            timed_out = 1'b0;
            break;
         end
      end
      start     = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      d1_start = 1'b0; d1_abort = 1'b0; d1_ready = 1'b1;
      step(); step();
      total++;
      if ({busy, done, mem_rd_en, out_valid, out_pixel, out_eol, out_eof} !== 7'b0) begin
         bad++;
         $display("FAIL reset_outputs got=%b want=0000000",
                  {busy, done, mem_rd_en, out_valid, out_pixel, out_eol, out_eof});
      end
      total++;
      if (mem_addr !== '0) begin
         bad++;
         $display("FAIL reset_addr got=%0d want=0", mem_addr);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_pass(input bit bp, input string tag);
      int h0 = obs_q.size();
      int a0 = addr_q.size();
      int d0 = done_n;
      int s0 = stall_bad;
      int sc, n, na;
      bit to;
      logic [2:0] e;
      run_frame(bp, -1, sc, to);
      step(); step(); step();
      total++;
      if (to !== 1'b0) begin bad++; $display("FAIL %s_timeout got=1 want=0", tag); end
      n = obs_q.size() - h0;
      total++;
      if (n != 12) begin bad++; $display("FAIL %s_count got=%0d want=12", tag, n); end
      for (int k = 0; k < 12 && k < n; k++) begin
         e = {(k % 2) == 0, (k % 4) == 3, k == 11};
         total++;
         if (obs_q[h0 + k] !== e) begin
            bad++;
            $display("FAIL %s_pix%0d got=%b want=%b", tag, k, obs_q[h0 + k], e);
         end
      end
      total++;
      if (done_n - d0 != 1) begin bad++; $display("FAIL %s_done_n got=%0d want=1", tag, done_n - d0); end
      if (!bp) begin
         total++;
         if (done_cyc - sc != 25) begin
            bad++;
            $display("FAIL %s_latency got=%0d want=25", tag, done_cyc - sc);
         end
      end
      total++;
      if (stall_bad != s0) begin
         bad++;
         $display("FAIL %s_stall got=%0d want=0", tag, stall_bad - s0);
      end
      na = addr_q.size() - a0;
      total++;
      if (na != 12) begin bad++; $display("FAIL %s_addr_count got=%0d want=12", tag, na); end
      for (int k = 0; k < 12 && k < na; k++) begin
         total++;
         if (addr_q[a0 + k] != k) begin
            bad++;
            $display("FAIL %s_addr%0d got=%0d want=%0d", tag, k, addr_q[a0 + k], k);
         end
      end
      total++;
      if ({busy, mem_addr} !== '0) begin
         bad++;
         $display("FAIL %s_after_done busy=%b addr=%0d want 0,0", tag, busy, mem_addr);
      end
   endtask

   task automatic test_abort();
      int h0 = obs_q.size();
      int a0 = addr_q.size();
      int d0 = done_n;
      int a1, h1, sc;
      bit found = 1'b0;
      bit to;
      start = 1'b1; out_ready = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if ((obs_q.size() - h0) == 5 && out_valid) begin
            abort = 1'b1;
            found = 1'b1;
            step();
            abort = 1'b0;
            break;
         end
         step();
      end
      total++;
      if (!found) begin bad++; $display("FAIL abort_reach got=0 want=1"); end
      total++;
      if ({busy, out_valid, done} !== 3'b000) begin
         bad++;
         $display("FAIL abort_idle got=%b want=000", {busy, out_valid, done});
      end
      for (int i = 0; i < 10; i++) step();
      total++;
      if (addr_q.size() - a0 != 6) begin
         bad++;
         $display("FAIL abort_reads got=%0d want=6", addr_q.size() - a0);
      end
      total++;
      if (obs_q.size() - h0 != 5) begin
         bad++;
         $display("FAIL abort_pixels got=%0d want=5", obs_q.size() - h0);
      end
      total++;
      if (done_n != d0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", done_n - d0); end
      a1 = addr_q.size();
      h1 = obs_q.size();
      run_frame(1'b0, -1, sc, to);
      total++;
      if (to || addr_q.size() <= a1 || addr_q[a1] != 0) begin
         bad++;
         $display("FAIL abort_restart_addr got=%0d want=0", (addr_q.size() > a1) ? addr_q[a1] : -1);
      end
      total++;
      if (obs_q.size() - h1 != 12) begin
         bad++;
         $display("FAIL abort_restart_count got=%0d want=12", obs_q.size() - h1);
      end
   endtask

   task automatic test_start_busy();
      int h0 = obs_q.size();
      int d0 = done_n;
      int sc;
      bit to;
      run_frame(1'b0, 5, sc, to);
      for (int i = 0; i < 8; i++) step();
      total++;
      if (to || obs_q.size() - h0 != 12) begin
         bad++;
         $display("FAIL busy_start_count got=%0d want=12", obs_q.size() - h0);
      end
      total++;
      if (done_n - d0 != 1) begin bad++; $display("FAIL busy_start_done got=%0d want=1", done_n - d0); end
      total++;
      if (done_cyc - sc != 25) begin
         bad++;
         $display("FAIL busy_start_latency got=%0d want=25", done_cyc - sc);
      end
   endtask

   task automatic test_rst_wait();
      int h0 = obs_q.size();
      bit found = 1'b0;
      start = 1'b1; out_ready = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if ((obs_q.size() - h0) == 4 && busy && !out_valid) begin
            found = 1'b1;
            break;
         end
         step();
      end
      total++;
      if (!found || out_eol !== 1'b1) begin
         bad++;
         $display("FAIL rst_wait_setup found=%b eol=%b want 1,1", found, out_eol);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if ({busy, done, mem_rd_en, out_valid, out_pixel, out_eol, out_eof, mem_addr} !== '0) begin
         bad++;
         $display("FAIL rst_wait_outputs got=%b addr=%0d want all 0",
                  {busy, done, mem_rd_en, out_valid, out_pixel, out_eol, out_eof}, mem_addr);
      end
      step();
   endtask

   task automatic test_degenerate();
      logic [2:0] got[3];
      logic [2:0] e;
      int n = 0;
      int seen = 0;
      d1_start = 1'b1;
      step();
      d1_start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (d1_valid) begin
            if (n < 3) got[n] = {d1_pixel, d1_eol, d1_eof};
            n++;
         end
         if (d1_done) begin
            seen++;
            break;
         end
      end
      total++;
      if (n != 3) begin bad++; $display("FAIL degen_count got=%0d want=3", n); end
      for (int k = 0; k < 3 && k < n; k++) begin
         e = {k < 2, 1'b1, k == 2};
         total++;
         if (got[k] !== e) begin
            bad++;
            $display("FAIL degen_pix%0d got=%b want=%b", k, got[k], e);
         end
      end
      total++;
      if (seen != 1) begin bad++; $display("FAIL degen_done got=%0d want=1", seen); end
   endtask

   initial begin
      test_reset();
      test_pass(1'b0, "basic");
      test_pass(1'b1, "backpressure");
      test_abort();
      test_start_busy();
      test_rst_wait();
      test_degenerate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/binary_frame_readout_ctrl.md
Name: binary_frame_readout_ctrl

Overview:
Sequences raster readout of the binarized text-extraction frame from the on-chip result buffer (1 bit/pixel, row-major) into a valid/ready pixel stream. The downstream sink is the output/dump stage. The block owns the row/column/address counters and the buffer read port, and it tags the end of each line and the end of the frame. A single start pulse triggers one full-frame pass.

Parameters:
WIDTH, 1920, pixels per row.
HEIGHT, 1080, rows per frame.
ADDR_W, 21, buffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  begin one frame pass; sampled only in IDLE.
abort  in  1  synchronous abandon of the current pass.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse after the last pixel is accepted.
mem_rd_en  out  1  buffer read strobe.
mem_addr  out  ADDR_W  buffer read address, row*WIDTH+col.
mem_rd_data  in  1  buffer read data, valid the cycle after mem_rd_en (registered read, latency 1).
out_valid  out  1  out_pixel/out_eol/out_eof are valid.
out_ready  in  1  sink accepts the current pixel.
out_pixel  out  1  pixel value.
out_eol  out  1  current pixel is col WIDTH-1.
out_eof  out  1  current pixel is col WIDTH-1 and row HEIGHT-1.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE; all outputs 0; col, row and addr counters 0.
- Counters:
  - col runs 0..WIDTH-1 and row runs 0..HEIGHT-1.
  - addr is a linear counter that increments by 1 per fetch. No multiplier is used.
  - When col wraps to 0, row increments. After the last pixel, all counters reset to 0.
- IDLE:
  - start=1 drives mem_rd_en=1 and mem_addr=0 combinationally in the same cycle, then moves to WAIT.
  - busy=0.
- WAIT:
  - Captures mem_rd_data into out_pixel.
  - Registers out_eol and out_eof from the counters of the fetched pixel.
  - Sets out_valid=1 and moves to HOLD.
- HOLD:
  - out_valid=1. out_pixel, out_eol and out_eof stay stable until a handshake (out_valid & out_ready).
  - Handshake and not the last pixel: advance the counters, assert mem_rd_en with the next address in this same cycle, and go to WAIT. out_valid drops to 0 for the WAIT cycle.
  - Handshake and the last pixel: go to DONE with out_valid=0.
  - No handshake: stay in HOLD with mem_rd_en=0.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- Throughput: with out_ready tied high, one pixel every 2 cycles. A full frame takes 2*WIDTH*HEIGHT+1 cycles from start to the done pulse.
- start while busy is ignored; no queuing.
- abort:
  - In any non-IDLE state, abort=1 moves the block to IDLE on the next edge.
  - Counters clear, out_valid=0, and no done pulse is issued.
  - abort has priority over a simultaneous handshake. A pixel handshaken in the abort cycle is considered not delivered.
- rst mid-pass: identical to the reset state, with priority over abort and start.
- mem_rd_en is never asserted while out_valid=1 and no handshake occurs, so at most one read is outstanding.
- WIDTH=1 or HEIGHT=1: out_eol is set on every pixel (WIDTH=1), and out_eof is set only on the final pixel.

Test Plan:
- Basic pass (WIDTH=4, HEIGHT=3, buffer=alternating 1,0, out_ready=1): start pulse -> 12 pixels 1,0,1,0,...; out_eol on pixels 3, 7 and 11 (0-based); out_eof only on pixel 11; done pulses exactly once, 25 cycles after start.
- Backpressure (out_ready random, ~50% duty): sequence and tags identical to the basic pass; out_pixel, out_eol and out_eof never change while out_valid=1 and out_ready=0; mem_rd_en never high in those cycles.
- Address sweep: log mem_addr on every mem_rd_en -> exactly 0..11, each once and in order; mem_addr=0 after done.
- Abort mid-row (abort at the 6th handshake) -> IDLE next cycle, busy=0, no done, no further mem_rd_en. A following start restarts at mem_addr=0.
- Start while busy (start pulsed at pixel 5) -> no effect: 12 pixels, one done. rst asserted in WAIT -> all outputs 0 next cycle.
- Degenerate sizes (WIDTH=1, HEIGHT=3): out_eol on all 3 pixels, out_eof on pixel 2 only.
